memdep_lfst: RTL and testbench

Last Fetched Store Table (LFST) for store-set memory dependence prediction. It sits at rename, directly downstream of the SSIT lookup that produces a store-set id (SSID) per instruction. For each renamed load or store with a valid SSID, it returns the robIdx of the youngest in-flight store of that set, so the issue queue can hold the instruction until that store issues. It records renamed stores as the new last store of their set and clears entries when those stores issue or the pipeline flushes.

---
 rtl/memdep_lfst_pkg.sv | 15 +
 rtl/memdep_lfst_bypass.sv | 29 ++
 rtl/memdep_lfst.sv | 109 ++++++++++
 tb/tb_memdep_lfst.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/memdep_lfst_pkg.sv
// Shared types for the LFST: table size, ROB index with wrap bit, store-set id.
package memdep_lfst_pkg;

    localparam int LFST_SIZE = 32;
    localparam int ROB_IDX_W = 7;

    // flip is the ROB wrap bit; a robIdx only matches when both fields match
    typedef struct packed {
        logic                 flip;
        logic [ROB_IDX_W-1:0] idx;
    } robIdx_t;

    typedef logic [$clog2(LFST_SIZE)-1:0] ssid_t;

endpackage

// File: rtl/memdep_lfst_bypass.sv
// Intra-group bypass for one rename lane: finds the youngest older store lane
// in the same group carrying the same store-set id.
module lfst_bypass
    import memdep_lfst_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int LANE   = 0,
    parameter int SSID_W = 5
) (
    input  logic [WIDTH-1:0]             st_elig_i,
    input  logic [WIDTH-1:0][SSID_W-1:0] ssid_i,
    input  robIdx_t [WIDTH-1:0]          rob_i,
    output logic                         hit_o,
    output robIdx_t                      rob_o
);

    // Scan oldest to youngest so the last match (youngest older store) wins
    always_comb begin
        hit_o = 1'b0;
        rob_o = '0;
        for (int j = 0; j < LANE; j++) begin
            if (st_elig_i[j] && (ssid_i[j] == ssid_i[LANE])) begin
                hit_o = 1'b1;
                rob_o = rob_i[j];
            end
        end
    end

endmodule

// File: rtl/memdep_lfst.sv
// Last Fetched Store Table: per store set, remembers the youngest in-flight
// store and reports it as a dependence for renamed loads/stores of that set.
module memdep_lfst
    import memdep_lfst_pkg::*;
#(
    parameter int SIZE    = LFST_SIZE,
    parameter int WIDTH   = 4,
    parameter int STPORTS = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_flush,
    input  logic [WIDTH-1:0]                 i_ren_vld,
    input  logic [WIDTH-1:0]                 i_ren_isLd,
    input  logic [WIDTH-1:0]                 i_ren_isSt,
    input  logic [WIDTH-1:0]                 i_ren_ssidVld,
    input  logic [WIDTH-1:0][$clog2(SIZE)-1:0] i_ren_ssid,
    input  robIdx_t [WIDTH-1:0]              i_ren_robIdx,
    input  logic [STPORTS-1:0]               i_stIssue_vld,
    input  robIdx_t [STPORTS-1:0]            i_stIssue_robIdx,
    output logic [WIDTH-1:0]                 o_dep_vld,
    output robIdx_t [WIDTH-1:0]              o_dep_robIdx
);

    localparam int SSID_W = $clog2(SIZE);

    // Flop-based table: every entry is compared against every issue port
    logic [SIZE-1:0]    valid_q, valid_d;
    robIdx_t [SIZE-1:0] st_rob_q, st_rob_d;

    logic [WIDTH-1:0]    elig, st_elig, byp_hit;
    robIdx_t [WIDTH-1:0] byp_rob;
    logic [WIDTH-1:0]    dep_vld_d, dep_vld_q;
    robIdx_t [WIDTH-1:0] dep_rob_d, dep_rob_q;

    assign elig    = i_ren_vld & i_ren_ssidVld & (i_ren_isLd | i_ren_isSt);
    assign st_elig = elig & i_ren_isSt;

    for (genvar k = 0; k < WIDTH; k++) begin : g_byp
        lfst_bypass #(
            .WIDTH  (WIDTH),
            .LANE   (k),
            .SSID_W (SSID_W)
        ) u_byp (
            .st_elig_i (st_elig),
            .ssid_i    (i_ren_ssid),
            .rob_i     (i_ren_robIdx),
            .hit_o     (byp_hit[k]),
            .rob_o     (byp_rob[k])
        );
    end

    // Lookup: in-group older store first, else the pre-update table entry
    always_comb begin
        dep_vld_d = '0;
        dep_rob_d = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (elig[k] && !i_flush) begin
                if (byp_hit[k]) begin
                    dep_vld_d[k] = 1'b1;
                    dep_rob_d[k] = byp_rob[k];
                end else if (valid_q[i_ren_ssid[k]]) begin
                    dep_vld_d[k] = 1'b1;
                    dep_rob_d[k] = st_rob_q[i_ren_ssid[k]];
                end
            end
        end
    end

    // Table update: issue clears, then rename writes override, flush overrides all
    always_comb begin
        valid_d  = valid_q;
        st_rob_d = st_rob_q;
        for (int p = 0; p < STPORTS; p++) begin
            for (int e = 0; e < SIZE; e++) begin
                if (i_stIssue_vld[p] && valid_q[e] && (st_rob_q[e] == i_stIssue_robIdx[p]))
                    valid_d[e] = 1'b0;
            end
        end
        // ascending lane order leaves the youngest store of each set in place
        for (int k = 0; k < WIDTH; k++) begin
            if (st_elig[k]) begin
                valid_d[i_ren_ssid[k]]  = 1'b1;
                st_rob_d[i_ren_ssid[k]] = i_ren_robIdx[k];
            end
        end
        if (i_flush)
            valid_d = '0;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            st_rob_q  <= '0;
            dep_vld_q <= '0;
            dep_rob_q <= '0;
        end else begin
            valid_q   <= valid_d;
            st_rob_q  <= st_rob_d;
            dep_vld_q <= dep_vld_d;
            dep_rob_q <= dep_rob_d;
        end
    end

    assign o_dep_vld    = dep_vld_q;
    assign o_dep_robIdx = dep_rob_q;

endmodule

// File: tb/tb_memdep_lfst.sv
// Bench for memdep_lfst: directed vector table, hand sequences for group
// bypass and reset, then randomized traffic against a set-level model.
module tb_memdep_lfst;
    import memdep_lfst_pkg::*;

    localparam int W = 4;
    localparam int P = 2;
    localparam int N = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_flush;
    logic [W-1:0]       i_ren_vld, i_ren_isLd, i_ren_isSt, i_ren_ssidVld;
    logic [W-1:0][4:0]  i_ren_ssid;
    robIdx_t [W-1:0]    i_ren_robIdx;
    logic [P-1:0]       i_stIssue_vld;
    robIdx_t [P-1:0]    i_stIssue_robIdx;
    logic [W-1:0]       o_dep_vld;
    robIdx_t [W-1:0]    o_dep_robIdx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    memdep_lfst #(.SIZE(N), .WIDTH(W), .STPORTS(P)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_flush          (i_flush),
        .i_ren_vld        (i_ren_vld),
        .i_ren_isLd       (i_ren_isLd),
        .i_ren_isSt       (i_ren_isSt),
        .i_ren_ssidVld    (i_ren_ssidVld),
        .i_ren_ssid       (i_ren_ssid),
        .i_ren_robIdx     (i_ren_robIdx),
        .i_stIssue_vld    (i_stIssue_vld),
        .i_stIssue_robIdx (i_stIssue_robIdx),
        .o_dep_vld        (o_dep_vld),
        .o_dep_robIdx     (o_dep_robIdx)
    );

    typedef struct {
        int       op;     // 0 none, 1 load, 2 store
        int       lane;
        bit       ssidv;
        int       ssid;
        bit [7:0] rob;
        bit       iv;
        int       iport;
        bit [7:0] irob;
        bit       flush;
        bit       ev;
        bit [7:0] er;
    } vec_t;

    vec_t vt[16];

    task automatic clr_in();
        i_flush = 0; i_ren_vld = '0; i_ren_isLd = '0; i_ren_isSt = '0;
        i_ren_ssidVld = '0; i_ren_ssid = '0; i_ren_robIdx = '0;
        i_stIssue_vld = '0; i_stIssue_robIdx = '0;
    endtask

    task automatic set_lane(int l, int op, bit sv, int ss, bit [7:0] rob);
        i_ren_vld[l] = (op != 0);
        i_ren_isLd[l] = (op == 1);
        i_ren_isSt[l] = (op == 2);
        i_ren_ssidVld[l] = sv;
        i_ren_ssid[l] = ss[4:0];
        i_ren_robIdx[l] = rob;
    endtask

    task automatic chk(string nm, int l, bit ev, bit [7:0] er);
        total++;
        if (o_dep_vld[l] !== ev || (ev && o_dep_robIdx[l] !== er)) begin
            bad++;
            $display("FAIL %s lane%0d: got vld=%0b rob=%02h, want vld=%0b rob=%02h",
                     nm, l, o_dep_vld[l], o_dep_robIdx[l], ev, er);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Set-level reference model
    bit       mv[N];
    bit [7:0] mr[N];
    bit       xv[W];
    bit [7:0] xr[W];

    task automatic model_step();
        bit st;
        for (int k = 0; k < W; k++) begin
            xv[k] = 0; xr[k] = 0;
            if (rst || i_flush) continue;
            if (!(i_ren_vld[k] && i_ren_ssidVld[k] && (i_ren_isLd[k] || i_ren_isSt[k]))) continue;
            for (int j = k - 1; j >= 0; j--) begin
                st = i_ren_vld[j] && i_ren_ssidVld[j] && i_ren_isSt[j];
                if (st && i_ren_ssid[j] == i_ren_ssid[k]) begin
                    xv[k] = 1; xr[k] = i_ren_robIdx[j]; break;
                end
            end
            if (!xv[k] && mv[i_ren_ssid[k]]) begin
                xv[k] = 1; xr[k] = mr[i_ren_ssid[k]];
            end
        end
        if (rst || i_flush) begin
            foreach (mv[e]) mv[e] = 0;
        end else begin
            bit nv[N];
            foreach (mv[e]) begin
                nv[e] = mv[e];
                for (int p = 0; p < P; p++)
                    if (i_stIssue_vld[p] && mv[e] && mr[e] == i_stIssue_robIdx[p]) nv[e] = 0;
            end
            for (int k = 0; k < W; k++)
                if (i_ren_vld[k] && i_ren_ssidVld[k] && i_ren_isSt[k]) begin
                    nv[i_ren_ssid[k]] = 1; mr[i_ren_ssid[k]] = i_ren_robIdx[k];
                end
            foreach (mv[e]) mv[e] = nv[e];
        end
    endtask

    initial begin
        //          op l sv ss rob    iv ip irob   fl ev er
        vt[0]  = '{1, 0, 1, 5, 8'h01, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[1]  = '{2, 0, 1, 5, 8'h12, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[2]  = '{1, 1, 1, 5, 8'h13, 0, 0, 8'h00, 0, 1, 8'h12};
        vt[3]  = '{2, 2, 1, 7, 8'h30, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[4]  = '{2, 0, 1, 7, 8'h31, 1, 0, 8'h30, 0, 1, 8'h30};
        vt[5]  = '{1, 3, 1, 7, 8'h32, 0, 0, 8'h00, 0, 1, 8'h31};
        vt[6]  = '{2, 1, 1, 4, 8'h45, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[7]  = '{0, 0, 0, 0, 8'h00, 1, 0, 8'hC5, 0, 0, 8'h00};
        vt[8]  = '{1, 2, 1, 4, 8'h46, 0, 0, 8'h00, 0, 1, 8'h45};
        vt[9]  = '{0, 0, 0, 0, 8'h00, 1, 1, 8'h45, 0, 0, 8'h00};
        vt[10] = '{1, 0, 1, 4, 8'h47, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[11] = '{1, 0, 0, 5, 8'h48, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[12] = '{1, 3, 1, 5, 8'h49, 0, 0, 8'h00, 0, 1, 8'h12};
        vt[13] = '{2, 0, 1, 1, 8'h50, 0, 0, 8'h00, 1, 0, 8'h00};
        vt[14] = '{1, 0, 1, 1, 8'h51, 0, 0, 8'h00, 0, 0, 8'h00};
        vt[15] = '{1, 1, 1, 5, 8'h52, 0, 0, 8'h00, 0, 0, 8'h00};

        clr_in();
        rst = 1;
        tick(); tick();
        rst = 0;
        for (int l = 0; l < W; l++) begin
            total++;
            if (o_dep_vld[l] !== 1'b0 || o_dep_robIdx[l] !== 8'h00) begin
                bad++;
                $display("FAIL reset lane%0d: got vld=%0b rob=%02h, want 0/00", l, o_dep_vld[l], o_dep_robIdx[l]);
            end
        end

        // Directed vector table
        foreach (vt[i]) begin
            clr_in();
            if (vt[i].op != 0) set_lane(vt[i].lane, vt[i].op, vt[i].ssidv, vt[i].ssid, vt[i].rob);
            i_stIssue_vld[vt[i].iport] = vt[i].iv;
            i_stIssue_robIdx[vt[i].iport] = vt[i].irob;
            i_flush = vt[i].flush;
            tick();
            for (int l = 0; l < W; l++)
                if (l == vt[i].lane) chk($sformatf("vec%0d", i), l, vt[i].ev, vt[i].er);
                else chk($sformatf("vec%0d", i), l, 1'b0, 8'h00);
        end

        // Group bypass: two stores and a load of set 3 in one group
        clr_in();
        set_lane(0, 2, 1, 3, 8'h20);
        set_lane(2, 2, 1, 3, 8'h22);
        set_lane(3, 1, 1, 3, 8'h23);
        tick();
        chk("grp", 0, 0, 8'h00);
        chk("grp", 1, 0, 8'h00);
        chk("grp", 2, 1, 8'h20);
        chk("grp", 3, 1, 8'h22);
        clr_in();
        set_lane(1, 1, 1, 3, 8'h24);
        tick();
        chk("grp_after", 1, 1, 8'h22);

        // Reset mid-operation, with rename traffic during reset
        clr_in();
        set_lane(0, 2, 1, 9, 8'h60);
        tick();
        clr_in();
        rst = 1;
        set_lane(0, 1, 1, 9, 8'h61);
        set_lane(1, 2, 1, 9, 8'h62);
        tick();
        chk("rst_mid", 0, 0, 8'h00);
        chk("rst_mid", 1, 0, 8'h00);
        rst = 0;
        clr_in();
        set_lane(2, 1, 1, 9, 8'h63);
        tick();
        chk("rst_after", 2, 0, 8'h00);

        // Randomized traffic against the model, starting from reset
        clr_in();
        rst = 1;
        model_step();
        tick();
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            clr_in();
            for (int l = 0; l < W; l++) begin
                int r = $urandom_range(0, 9);
                set_lane(l, (r < 2) ? 0 : ((r < 6) ? 1 : 2), ($urandom_range(0, 9) != 0),
                         $urandom_range(0, 7), 8'($urandom));
            end
            for (int p = 0; p < P; p++) begin
                i_stIssue_vld[p] = ($urandom_range(0, 9) < 4);
                i_stIssue_robIdx[p] = mr[$urandom_range(0, 7)] ^ (($urandom_range(0, 7) == 0) ? 8'h80 : 8'h00);
            end
            if ($urandom_range(0, 9) == 0) i_stIssue_robIdx[1] = i_stIssue_robIdx[0];
            i_flush = ($urandom_range(0, 49) == 0);
            rst = ($urandom_range(0, 99) == 0);
            model_step();
            tick();
            for (int l = 0; l < W; l++) chk("rand", l, xv[l], xr[l]);
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
